// File: rtl/unstriping_lane_scheduler.sv
// Re-merges two striped lanes into one ordered stream through per-lane elastic FIFOs.
// Optional lane-skew checker is built when UNSTRIPE_SKEW_CHK_EN is defined.
module unstriping_lane_scheduler #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int SKEW_MAX = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] lane_0,
    input  logic             valid_1,
    input  logic [WIDTH-1:0] lane_1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             full_0,
    output logic             full_1,
    output logic             ovf_0,
    output logic             ovf_1,
    output logic             next_lane,
    output logic             skew_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic {
        EXPECT_L0 = 1'b0,
        EXPECT_L1 = 1'b1
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mem_0 [DEPTH];
    logic [WIDTH-1:0] mem_1 [DEPTH];
    logic [AW-1:0]    wr_ptr_0, rd_ptr_0, wr_ptr_1, rd_ptr_1;
    logic [CW-1:0]    count_0, count_1;
    logic             pop_0, pop_1, push_0, push_1;

    // A full lane still accepts a word when its head leaves on the same edge.
    always_comb begin
        state_next = state;
        pop_0      = 1'b0;
        pop_1      = 1'b0;
        case (state)
            EXPECT_L0: if (count_0 != '0) begin
                pop_0      = 1'b1;
                state_next = EXPECT_L1;
            end
            EXPECT_L1: if (count_1 != '0) begin
                pop_1      = 1'b1;
                state_next = EXPECT_L0;
            end
            default: state_next = EXPECT_L0;
        endcase
        push_0 = valid_0 && ((count_0 != CNT_FULL) || pop_0);
        push_1 = valid_1 && ((count_1 != CNT_FULL) || pop_1);
    end

    assign full_0    = (count_0 == CNT_FULL);
    assign full_1    = (count_1 == CNT_FULL);
    assign next_lane = state;

    always_ff @(posedge clk) begin
        if (push_0) mem_0[wr_ptr_0] <= lane_0;
        if (push_1) mem_1[wr_ptr_1] <= lane_1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EXPECT_L0;
            wr_ptr_0  <= '0;
            rd_ptr_0  <= '0;
            wr_ptr_1  <= '0;
            rd_ptr_1  <= '0;
            count_0   <= '0;
            count_1   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            ovf_0     <= 1'b0;
            ovf_1     <= 1'b0;
        end else begin
            state     <= state_next;
            valid_out <= pop_0 || pop_1;
            if (pop_0) data_out <= mem_0[rd_ptr_0];
            else if (pop_1) data_out <= mem_1[rd_ptr_1];
            if (push_0) wr_ptr_0 <= wr_ptr_0 + AW'(1);
            if (push_1) wr_ptr_1 <= wr_ptr_1 + AW'(1);
            if (pop_0)  rd_ptr_0 <= rd_ptr_0 + AW'(1);
            if (pop_1)  rd_ptr_1 <= rd_ptr_1 + AW'(1);
            case ({push_0, pop_0})
                2'b10:   count_0 <= count_0 + CW'(1);
                2'b01:   count_0 <= count_0 - CW'(1);
                default: count_0 <= count_0;
            endcase
            case ({push_1, pop_1})
                2'b10:   count_1 <= count_1 + CW'(1);
                2'b01:   count_1 <= count_1 - CW'(1);
                default: count_1 <= count_1;
            endcase
            if (valid_0 && !push_0) ovf_0 <= 1'b1;
            if (valid_1 && !push_1) ovf_1 <= 1'b1;
        end
    end

`ifdef UNSTRIPE_SKEW_CHK_EN
    logic [CW-1:0] skew_diff;

    // Judged on the counts as they stand before this edge's push/pop.
    assign skew_diff = (count_0 > count_1) ? (count_0 - count_1) : (count_1 - count_0);

    always_ff @(posedge clk) begin
        if (reset)
            skew_err <= 1'b0;
        else if (skew_diff > CW'(SKEW_MAX))
            skew_err <= 1'b1;
    end
`else
    assign skew_err = 1'b0;
`endif

endmodule

// File: tb/tb_unstriping_lane_scheduler.sv
// Bench for unstriping_lane_scheduler: directed spec scenarios plus random traffic
// checked against a queue-based reference model.
module tb_unstriping_lane_scheduler;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int SKEW_MAX = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             valid_0 = 1'b0;
    logic [WIDTH-1:0] lane_0 = '0;
    logic             valid_1 = 1'b0;
    logic [WIDTH-1:0] lane_1 = '0;
    logic [WIDTH-1:0] data_out;
    logic             valid_out, full_0, full_1, ovf_0, ovf_1, next_lane, skew_err;

    unstriping_lane_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKEW_MAX(SKEW_MAX)) dut (
        .clk(clk), .reset(reset),
        .valid_0(valid_0), .lane_0(lane_0), .valid_1(valid_1), .lane_1(lane_1),
        .data_out(data_out), .valid_out(valid_out), .full_0(full_0), .full_1(full_1),
        .ovf_0(ovf_0), .ovf_1(ovf_1), .next_lane(next_lane), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] got[$];
    bit               m_exp;
    logic [WIDTH-1:0] m_data;
    bit               m_valid, m_ovf0, m_ovf1, m_skew;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_out"}, WIDTH'(valid_out), WIDTH'(m_valid));
        chk({tag, ".data_out"},  data_out, m_data);
        chk({tag, ".full_0"},    WIDTH'(full_0), WIDTH'(q0.size() == DEPTH));
        chk({tag, ".full_1"},    WIDTH'(full_1), WIDTH'(q1.size() == DEPTH));
        chk({tag, ".ovf_0"},     WIDTH'(ovf_0), WIDTH'(m_ovf0));
        chk({tag, ".ovf_1"},     WIDTH'(ovf_1), WIDTH'(m_ovf1));
        chk({tag, ".next_lane"}, WIDTH'(next_lane), WIDTH'(m_exp));
        chk({tag, ".skew_err"},  WIDTH'(skew_err), WIDTH'(m_skew));
    endtask

    // One clock: the model consumes the same inputs the DUT sees at this edge.
    task automatic cycle(input string tag, input bit v0, input logic [WIDTH-1:0] d0,
                         input bit v1, input logic [WIDTH-1:0] d1);
        bit p0, p1;
`ifdef UNSTRIPE_SKEW_CHK_EN
        int diff;
        diff = q0.size() - q1.size();
        if (diff < 0) diff = -diff;
        if (diff > SKEW_MAX) m_skew = 1'b1;
`endif
        valid_0 = v0; lane_0 = d0; valid_1 = v1; lane_1 = d1;
        p0 = !m_exp && (q0.size() > 0);
        p1 = m_exp && (q1.size() > 0);
        m_valid = p0 || p1;
        if (p0) begin m_data = q0.pop_front(); m_exp = 1'b1; end
        else if (p1) begin m_data = q1.pop_front(); m_exp = 1'b0; end
        if (v0) begin if (q0.size() < DEPTH) q0.push_back(d0); else m_ovf0 = 1'b1; end
        if (v1) begin if (q1.size() < DEPTH) q1.push_back(d1); else m_ovf1 = 1'b1; end
        @(posedge clk);
        #1;
        valid_0 = 1'b0; valid_1 = 1'b0;
        check_all(tag);
        if (valid_out) got.push_back(data_out);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete(); q1.delete(); got.delete();
        m_exp = 1'b0; m_data = '0; m_valid = 1'b0;
        m_ovf0 = 1'b0; m_ovf1 = 1'b0; m_skew = 1'b0;
        check_all(tag);
    endtask

    task automatic check_got(input string tag, input int n, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                             input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] e[4];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        chk({tag, ".count"}, WIDTH'(got.size()), WIDTH'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s.word%0d", tag, i), got[i], e[i]);
    endtask

    initial begin
        do_reset("reset");
        idle("idle", 4);
        chk("idle.data_out_zero", data_out, 32'h0);

        // In-order merge
        do_reset("rst_order");
        cycle("order", 1'b1, 32'hFFFFFFFF, 1'b0, '0);
        cycle("order", 1'b0, '0, 1'b1, 32'h88888888);
        cycle("order", 1'b1, 32'h77777777, 1'b0, '0);
        idle("order", 3);
        check_got("order", 3, 32'hFFFFFFFF, 32'h88888888, 32'h77777777, '0);

        // Lane 1 leads by two clocks
        do_reset("rst_skew");
        cycle("skew", 1'b0, '0, 1'b1, 32'h44444444);
        cycle("skew", 1'b0, '0, 1'b1, 32'h55555555);
        chk("skew.stalled", WIDTH'(valid_out), 32'h0);
        cycle("skew", 1'b1, 32'h99999999, 1'b0, '0);
        cycle("skew", 1'b1, 32'hCCCCCCCC, 1'b0, '0);
        idle("skew", 5);
        check_got("skew", 4, 32'h99999999, 32'h44444444, 32'hCCCCCCCC, 32'h55555555);

        // Lane 0 overflow with lane 1 idle
        do_reset("rst_ovf");
        for (int i = 0; i < 6; i++) cycle("ovf", 1'b1, 32'hA0000000 + i, 1'b0, '0);
        chk("ovf.flag", WIDTH'(ovf_0), 32'h1);
        chk("ovf.full", WIDTH'(full_0), 32'h1);
        idle("ovf", 3);
        chk("ovf.sticky", WIDTH'(ovf_0), 32'h1);
        check_got("ovf", 1, 32'hA0000000, '0, '0, '0);

        // Three lane-1 words buffered, then reset
        do_reset("rst_buf");
        for (int i = 0; i < 3; i++) cycle("buf", 1'b0, '0, 1'b1, 32'hB0000000 + i);
        idle("buf", 1);
`ifdef UNSTRIPE_SKEW_CHK_EN
        chk("skew_chk.set", WIDTH'(skew_err), 32'h1);
`else
        chk("skew_chk.off", WIDTH'(skew_err), 32'h0);
`endif
        do_reset("rst_mid");
        chk("rst_mid.next_lane", WIDTH'(next_lane), 32'h0);
        chk("rst_mid.skew_clr", WIDTH'(skew_err), 32'h0);
        cycle("post_rst", 1'b1, 32'hD0D0D0D0, 1'b0, '0);
        cycle("post_rst", 1'b0, '0, 1'b1, 32'hE0E0E0E0);
        idle("post_rst", 3);
        check_got("post_rst", 2, 32'hD0D0D0D0, 32'hE0E0E0E0, '0, '0);

        // Random traffic with one mid-run reset
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("rst_rand_mid");
            cycle("rand", $urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 3) != 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
